// File: rtl/uart_rx.sv
// uart_rx: UART receiver that recovers start + WIDTH data bits (LSB first) + stop, sampling each bit at mid-period.
// Define UART_RX_PARITY_EN to expect a parity bit before stop and expose uart_rx_parity_err.
module uart_rx #(
  parameter int WIDTH        = 8,
  parameter int BPS          = 9_600,
  parameter int SYS_CLK_FREQ = 50_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  input  logic             uart_rx_in,
  output logic [WIDTH-1:0] uart_rx_data,
  output logic             uart_rx_done,
  output logic             uart_rx_frame_err,
  output logic             uart_rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic             uart_rx_parity_err
`endif
);

  localparam int BAUD_CNT_MAX = SYS_CLK_FREQ / BPS;
  localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam int IDX_W        = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MAX / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_ODD = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic             parity_err_q, parity_err_d;
  logic             par_bad_q, par_bad_d;
`endif

  logic fall_edge;
  logic mid_bit;
  logic shift_en;

  assign fall_edge = prev_q & ~sync2_q;
  assign mid_bit   = (cnt_q == CNT_MID);

  always_comb begin
    sync1_d = uart_rx_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Counter only runs inside a frame, so it is already zero when the start edge arrives.
  always_comb begin
    cnt_d = '0;
    if (state_q != S_IDLE) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shreg
      assign shreg_d[gi] = (shift_en && (bit_idx_q == IDX_W'(gi))) ? sync2_q : shreg_q[gi];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    data_d      = data_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
    shift_en    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    par_bad_d    = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (fall_edge) begin
          state_d   = S_START;
          bit_idx_d = '0;
        end
      end
      S_START: begin
        if (mid_bit) begin
          state_d   = sync2_q ? S_IDLE : S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (mid_bit) begin
          shift_en = 1'b1;
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid_bit) begin
          par_bad_d = sync2_q != ((^shreg_q) ^ PARITY_ODD);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid-stop so a back-to-back start bit is still seen as a fresh edge.
        if (mid_bit) begin
          state_d = S_IDLE;
          if (!sync2_q) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            data_d = shreg_q;
            done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_done      = done_q;
  assign uart_rx_frame_err = frame_err_q;
  assign uart_rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign uart_rx_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives directed and randomized serial frames and checks uart_rx against a frame-level model.
`timescale 1ns/100ps
module tb_uart_rx;
  localparam int  WIDTH        = 8;
  localparam int  SYS_CLK_FREQ = 50_000_000;
  localparam int  BPS          = 3_125_000;
  localparam int  B            = SYS_CLK_FREQ / BPS;
  localparam int  CLK_NS       = 20;
  localparam real BT           = B * CLK_NS;
`ifdef UART_RX_PARITY_EN
  localparam int  NB = WIDTH + 2;
`else
  localparam int  NB = WIDTH + 1;
`endif
  localparam int  LAT_NOM = (NB * B + B / 2 + 3) * CLK_NS;
  localparam int  LAT_LO  = LAT_NOM - CLK_NS;
  localparam int  LAT_HI  = LAT_NOM + 2 * CLK_NS;

  logic             sys_clk = 1'b0;
  logic             sys_reset_n = 1'b0;
  logic             uart_rx_in = 1'b1;
  logic [WIDTH-1:0] uart_rx_data;
  logic             uart_rx_done;
  logic             uart_rx_frame_err;
  logic             uart_rx_busy;
  logic             uart_rx_parity_err;

  always #(CLK_NS / 2) sys_clk = ~sys_clk;

  uart_rx #(.WIDTH(WIDTH), .BPS(BPS), .SYS_CLK_FREQ(SYS_CLK_FREQ)) dut (
    .sys_clk           (sys_clk),
    .sys_reset_n       (sys_reset_n),
    .uart_rx_in        (uart_rx_in),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_done      (uart_rx_done),
    .uart_rx_frame_err (uart_rx_frame_err),
`ifdef UART_RX_PARITY_EN
    .uart_rx_parity_err(uart_rx_parity_err),
`endif
    .uart_rx_busy      (uart_rx_busy)
  );
`ifndef UART_RX_PARITY_EN
  assign uart_rx_parity_err = 1'b0;
`endif

  // kind: 1 = done, 2 = frame error, 3 = parity error
  typedef struct {
    int         kind;
    logic [7:0] data;
    realtime    tl;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         n_done = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  logic [7:0] model_data = 8'h00;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: every pulse must match the next queued frame outcome and its latency.
  initial begin : compare
    bit      rst_edge;
    int      npulse;
    int      kind;
    ev_t     e;
    realtime lat;
    forever begin
      @(posedge sys_clk);
      rst_edge = !sys_reset_n;
      @(negedge sys_clk);
      if (rst_edge) begin
        model_data = 8'h00;
        chk({uart_rx_done, uart_rx_frame_err, uart_rx_parity_err, uart_rx_busy} === 4'b0000,
            "reset_outputs", {uart_rx_done, uart_rx_frame_err, uart_rx_parity_err, uart_rx_busy}, 0);
      end else begin
        npulse = int'(uart_rx_done) + int'(uart_rx_frame_err) + int'(uart_rx_parity_err);
        if (npulse > 1) begin
          chk(1'b0, "exclusive_pulses", npulse, 1);
        end else if (npulse == 1) begin
          kind = uart_rx_done ? 1 : (uart_rx_frame_err ? 2 : 3);
          if (kind == 1) n_done++;
          else if (kind == 2) n_ferr++;
          else n_perr++;
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_pulse", kind, 0);
          end else begin
            e   = exp_q.pop_front();
            lat = $realtime - e.tl;
            chk(kind == e.kind, "pulse_kind", kind, e.kind);
            chk(lat >= LAT_LO && lat <= LAT_HI, "latency_ns", longint'(lat), LAT_NOM);
            if (kind == 1) model_data = e.data;
          end
        end
      end
      chk(uart_rx_data === model_data, "data", uart_rx_data, model_data);
    end
  end

  task automatic send_frame(input logic [7:0] d, input real bt, input bit stop_val,
                            input int kind, input bit chk_busy);
    ev_t e;
    if (kind != 0) begin
      e.kind = kind;
      e.data = d;
      e.tl   = $realtime;
      exp_q.push_back(e);
    end
    uart_rx_in = 1'b0;
    #(bt);
    for (int i = 0; i < WIDTH; i++) begin
      uart_rx_in = d[i];
      if (i == 1 && chk_busy) begin
        #(bt / 2);
        chk(uart_rx_busy === 1'b1, "busy_mid_frame", uart_rx_busy, 1);
        #(bt / 2);
      end else begin
        #(bt);
      end
    end
`ifdef UART_RX_PARITY_EN
    uart_rx_in = (^d) ^ (kind == 3);
    #(bt);
`endif
    uart_rx_in = stop_val;
    #(bt);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * (NB + 1) * B; i++) begin
      @(negedge sys_clk);
      if (exp_q.size() == 0 && uart_rx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(1'b0, "idle_timeout", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] d;
    real        bt;
    bit         ferr;
    int         kind;
    sys_reset_n = 1'b0;
    uart_rx_in  = 1'b1;
    repeat (3) @(posedge sys_clk);
    #3 sys_reset_n = 1'b1;
    #(2 * BT + 0.3);

    send_frame(8'h55, BT, 1'b1, 1, 1'b1);
    wait_idle();
    chk(uart_rx_data === 8'h55, "t1_data", uart_rx_data, 8'h55);
    chk(uart_rx_busy === 1'b0, "t1_busy_idle", uart_rx_busy, 0);
    chk(n_ferr == 0, "t1_no_ferr", n_ferr, 0);

    send_frame(8'hA3, BT, 1'b1, 1, 1'b1);
    send_frame(8'h0F, BT, 1'b1, 1, 1'b1);
    wait_idle();
    chk(uart_rx_data === 8'h0F, "t2_data", uart_rx_data, 8'h0F);
    chk(n_done == 3, "t2_done_count", n_done, 3);

    uart_rx_in = 1'b0;
    #(4 * CLK_NS);
    uart_rx_in = 1'b1;
    #(3 * CLK_NS);
    @(negedge sys_clk);
    chk(uart_rx_busy === 1'b1, "glitch_busy", uart_rx_busy, 1);
    #(BT);
    @(negedge sys_clk);
    chk(uart_rx_busy === 1'b0, "glitch_idle", uart_rx_busy, 0);
    chk(uart_rx_data === 8'h0F, "glitch_data", uart_rx_data, 8'h0F);

    send_frame(8'h3C, BT, 1'b0, 2, 1'b1);
    #(20 * BT);
    @(negedge sys_clk);
    chk(uart_rx_busy === 1'b0, "break_no_start", uart_rx_busy, 0);
    chk(n_ferr == 1, "ferr_count", n_ferr, 1);
    chk(uart_rx_data === 8'h0F, "ferr_data_held", uart_rx_data, 8'h0F);
    uart_rx_in = 1'b1;
    #(2 * BT);

    fork
      send_frame(8'hFF, BT, 1'b1, 0, 1'b1);
      begin
        #(5.5 * BT);
        @(negedge sys_clk);
        sys_reset_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_reset_n = 1'b1;
      end
    join
    #(BT);
    @(negedge sys_clk);
    chk(uart_rx_data === 8'h00, "reset_data", uart_rx_data, 0);
    send_frame(8'h81, BT, 1'b1, 1, 1'b1);
    wait_idle();
    chk(uart_rx_data === 8'h81, "t5_data", uart_rx_data, 8'h81);

    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       bt = BT * 0.98;
        1:       bt = BT * 1.02;
        default: bt = BT;
      endcase
      ferr = ($urandom_range(0, 7) == 0);
      kind = ferr ? 2 : 1;
`ifdef UART_RX_PARITY_EN
      if (!ferr && $urandom_range(0, 7) == 0) kind = 3;
`endif
      send_frame(d, bt, !ferr, kind, 1'b1);
      if (ferr) begin
        uart_rx_in = 1'b1;
        #(bt);
      end
      #(($urandom_range(0, 2)) * bt / 2);
    end
    wait_idle();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, BT, 1'b1, 1, 1'b1);
    wait_idle();
    chk(uart_rx_data === 8'h07, "t6_parity_good", uart_rx_data, 8'h07);
    send_frame(8'h07, BT, 1'b1, 3, 1'b1);
    wait_idle();
    chk(n_perr > 0, "t6_parity_err_seen", n_perr, 1);
`endif

    #(2 * BT);
    chk(exp_q.size() == 0, "all_frames_received", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
